// File: rtl/capture_pkg.sv
// Shared types and helpers for the capture buffer: FSM state encoding and
// address-width derivation from the sample memory depth.
package capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2,
    ST_READOUT = 2'd3
  } state_t;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port sample memory: one write port, one read port with a
// registered 1-cycle read latency so it maps onto block RAM.
module sample_ram #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/capture_buffer.sv
// Gated probe-bus capture into sample memory at a programmable rate, followed
// by a valid/ready readout with a prefetched output register.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | waiting for a rise of the registered gate
// ST_CAPTURE | sampling every div+1 clocks until gate low or memory full
// ST_DONE    | holding o_count, waiting for i_read_start
// ST_READOUT | streaming samples 0..o_count-1 over valid/ready
module capture_buffer
  import capture_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 1024,
  parameter int DIV_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_run,
  input  logic [DIV_WIDTH-1:0]   i_div,
  input  logic                   i_read_start,
  input  logic                   i_rd_ready,
  output logic [WIDTH-1:0]       o_rd_data,
  output logic                   o_rd_valid,
  output logic                   o_rd_last,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_busy
);

  localparam int ADDR_W  = addr_w(DEPTH);
  localparam int COUNT_W = ADDR_W + 1;
  localparam logic [COUNT_W-1:0] FULL_CNT = COUNT_W'(DEPTH);
  localparam logic [COUNT_W-1:0] LAST_CNT = COUNT_W'(DEPTH - 1);

  state_t state, state_nx;

  logic                 run_q, run_prev;
  logic                 gate_rise;
  logic [DIV_WIDTH-1:0] div_lat, div_cnt;
  logic [ADDR_W-1:0]    wr_ptr;
  logic [COUNT_W-1:0]   count;

  logic                 we;
  logic [ADDR_W-1:0]    waddr;
  logic [WIDTH-1:0]     rdata;

  // rd_idx is the sample index currently held (or being fetched) in the RAM
  // output register; ram_valid says that index is still part of the capture.
  logic [COUNT_W-1:0]   rd_idx, rd_idx_nx;
  logic                 ram_valid, ram_valid_nx;
  logic                 load_out, xfer;

  logic [WIDTH-1:0]     out_data;
  logic                 out_valid, out_last;

  assign gate_rise = run_q & ~run_prev;
  assign xfer      = out_valid & i_rd_ready;
  assign load_out  = (state == ST_READOUT) & ram_valid & (~out_valid | i_rd_ready);

  sample_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (i_clk),
    .we    (we),
    .waddr (waddr),
    .wdata (i_data),
    .raddr (rd_idx_nx[ADDR_W-1:0]),
    .rdata (rdata)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      run_q    <= 1'b0;
      run_prev <= 1'b0;
    end else begin
      run_q    <= i_run;
      run_prev <= run_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    we           = 1'b0;
    waddr        = wr_ptr;
    rd_idx_nx    = rd_idx;
    ram_valid_nx = ram_valid;
    case (state)
      ST_IDLE: begin
        if (gate_rise) begin
          state_nx = ST_CAPTURE;
          we       = 1'b1;
          waddr    = '0;
        end
      end
      ST_CAPTURE: begin
        if (!run_q) begin
          state_nx = ST_DONE;
        end else if (div_cnt == '0) begin
          we = 1'b1;
          if (count == LAST_CNT) begin
            state_nx = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (i_read_start) begin
          state_nx     = ST_READOUT;
          rd_idx_nx    = '0;
          ram_valid_nx = 1'b1;
        end
      end
      ST_READOUT: begin
        if (load_out) begin
          rd_idx_nx    = rd_idx + 1'b1;
          ram_valid_nx = (rd_idx + 1'b1) < count;
        end
        if (xfer && out_last) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Divider is a down-counter reloaded with the latched rate on every sample.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div_lat <= '0;
      div_cnt <= '0;
      wr_ptr  <= '0;
      count   <= '0;
    end else begin
      if (state == ST_IDLE && gate_rise) begin
        div_lat <= i_div;
        div_cnt <= i_div;
        wr_ptr  <= ADDR_W'(1);
        count   <= COUNT_W'(1);
      end else if (state == ST_CAPTURE && run_q) begin
        if (div_cnt == '0) begin
          div_cnt <= div_lat;
          wr_ptr  <= wr_ptr + 1'b1;
          count   <= count + 1'b1;
        end else begin
          div_cnt <= div_cnt - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_idx    <= '0;
      ram_valid <= 1'b0;
    end else begin
      rd_idx    <= rd_idx_nx;
      ram_valid <= ram_valid_nx;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (load_out) begin
      out_data  <= rdata;
      out_valid <= 1'b1;
      out_last  <= (rd_idx == count - 1'b1);
    end else if (xfer) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  assign o_rd_data  = out_data;
  assign o_rd_valid = out_valid;
  assign o_rd_last  = out_last;
  assign o_count    = count;
  assign o_full     = (count == FULL_CNT);
  assign o_busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_capture_buffer.sv
// Randomized scoreboard bench for capture_buffer: a gate/rate reference model
// predicts the stored samples, a negedge monitor checks every readout transfer.
module tb_capture_buffer;

  localparam int WIDTH     = 8;
  localparam int DEPTH     = 16;
  localparam int DIV_WIDTH = 16;
  localparam int CW        = $clog2(DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [WIDTH-1:0]     i_data;
  logic                 i_run;
  logic [DIV_WIDTH-1:0] i_div;
  logic                 i_read_start;
  logic                 i_rd_ready;
  logic [WIDTH-1:0]     o_rd_data;
  logic                 o_rd_valid;
  logic                 o_rd_last;
  logic [CW-1:0]        o_count;
  logic                 o_full;
  logic                 o_busy;

  always #5 clk = ~clk;

  capture_buffer #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .DIV_WIDTH (DIV_WIDTH)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_data       (i_data),
    .i_run        (i_run),
    .i_div        (i_div),
    .i_read_start (i_read_start),
    .i_rd_ready   (i_rd_ready),
    .o_rd_data    (o_rd_data),
    .o_rd_valid   (o_rd_valid),
    .o_rd_last    (o_rd_last),
    .o_count      (o_count),
    .o_full       (o_full),
    .o_busy       (o_busy)
  );

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             last;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;

  exp_t             sb[$];
  exp_t             mon_e;
  logic [WIDTH-1:0] exp_samples[$];
  logic             run_log[$];
  logic [WIDTH-1:0] data_log[$];

  logic             stalled = 1'b0;
  logic [WIDTH-1:0] held_data;
  logic             held_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Gate seen by the design in cycle k is the i_run driven in cycle k-1.
  function automatic bit gate_at(input int k);
    if (k <= 0 || k > run_log.size()) return 1'b0;
    return run_log[k-1];
  endfunction

  // Samples start on the first gate rise, repeat every div+1 cycles while
  // the gate stays high, and stop after DEPTH samples.
  function automatic void build_expected(input int div);
    int r;
    r = -1;
    exp_samples.delete();
    for (int k = 0; k < data_log.size(); k++) begin
      if (gate_at(k) && !gate_at(k - 1)) begin
        r = k;
        break;
      end
    end
    if (r < 0) return;
    for (int k = r; k < data_log.size(); k++) begin
      if (!gate_at(k)) break;
      if (((k - r) % (div + 1)) == 0) exp_samples.push_back(data_log[k]);
      if (exp_samples.size() == DEPTH) break;
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", 32'(o_rd_valid), 32'd1);
        check("stall_data", 32'(o_rd_data), 32'(held_data));
        check("stall_last", 32'(o_rd_last), 32'(held_last));
      end
      if (o_rd_valid && i_rd_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sample: got %0h expected none", o_rd_data);
        end else begin
          mon_e = sb.pop_front();
          check("rd_data", 32'(o_rd_data), 32'(mon_e.data));
          check("rd_last", 32'(o_rd_last), 32'(mon_e.last));
        end
        xfers++;
        stalled = 1'b0;
      end else if (o_rd_valid) begin
        stalled   = 1'b1;
        held_data = o_rd_data;
        held_last = o_rd_last;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic do_capture(input logic [DIV_WIDTH-1:0] div, input int n_high,
                            input int n_total, input bit incr, input logic [WIDTH-1:0] base);
    i_run = 1'b0;
    step();
    step();
    run_log.delete();
    data_log.delete();
    i_div = div;
    for (int c = 0; c < n_total; c++) begin
      i_run  = (c < n_high);
      i_data = incr ? WIDTH'(base + c) : WIDTH'($urandom);
      run_log.push_back(i_run);
      data_log.push_back(i_data);
      step();
    end
    i_run = 1'b0;
    build_expected(int'(div));
    check("cap_count", 32'(o_count), 32'(exp_samples.size()));
    check("cap_full", 32'(o_full), 32'(exp_samples.size() == DEPTH));
    check("cap_busy", 32'(o_busy), 32'(exp_samples.size() > 0));
  endtask

  function automatic logic ready_for(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (c % 3) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push_expected();
    exp_t e;
    for (int i = 0; i < exp_samples.size(); i++) begin
      e.data = exp_samples[i];
      e.last = (i == exp_samples.size() - 1);
      sb.push_back(e);
    end
  endtask

  task automatic do_readout(input int mode, input bit poke_run);
    int x0;
    push_expected();
    x0 = xfers;
    i_rd_ready   = 1'b0;
    i_read_start = 1'b1;
    step();
    i_read_start = 1'b0;
    check("valid_lat1", 32'(o_rd_valid), 32'd0);
    step();
    check("valid_lat2", 32'(o_rd_valid), 32'd1);
    for (int c = 0; c < 400 && o_busy; c++) begin
      i_rd_ready = ready_for(mode, c);
      if (poke_run && c == 2) i_run = 1'b1;
      step();
    end
    check("ro_idle", 32'(o_busy), 32'd0);
    check("ro_valid_end", 32'(o_rd_valid), 32'd0);
    check("ro_xfers", 32'(xfers - x0), 32'(exp_samples.size()));
    check("ro_sb_empty", 32'(sb.size()), 32'd0);
    check("ro_count_hold", 32'(o_count), 32'(exp_samples.size()));
    i_rd_ready = 1'b0;
    if (poke_run) begin
      step();
      step();
      check("poke_no_rearm", 32'(o_busy), 32'd0);
      i_run = 1'b0;
      step();
    end
    sb.delete();
  endtask

  initial begin
    int x0;
    int n;
    rst          = 1'b1;
    i_data       = '0;
    i_run        = 1'b0;
    i_div        = '0;
    i_read_start = 1'b0;
    i_rd_ready   = 1'b0;
    step();
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_full", 32'(o_full), 32'd0);
    check("rst_valid", 32'(o_rd_valid), 32'd0);
    check("rst_last", 32'(o_rd_last), 32'd0);
    check("rst_data", 32'(o_rd_data), 32'd0);
    step();
    rst = 1'b0;
    step();

    do_capture(16'd0, 5, 8, 1'b1, 8'h10);
    do_readout(0, 1'b0);

    do_capture(16'd3, 12, 15, 1'b0, 8'h00);
    do_readout(0, 1'b0);

    do_capture(16'd0, 40, 43, 1'b0, 8'h00);
    do_readout(1, 1'b0);

    do_capture(16'd0, 4, 7, 1'b0, 8'h00);
    do_readout(1, 1'b0);

    do_capture(16'd0, 16, 19, 1'b1, 8'h40);
    do_readout(2, 1'b0);

    do_capture(16'd1, 8, 11, 1'b0, 8'h00);
    do_readout(1, 1'b1);

    do_capture(16'hFFFF, 3, 6, 1'b0, 8'h00);
    do_readout(0, 1'b0);

    // Reset in the middle of a capture.
    i_div = '0;
    i_run = 1'b1;
    for (n = 0; n < 50 && o_count != CW'(7); n++) begin
      i_data = WIDTH'($urandom);
      step();
    end
    check("mid_cap_count7", 32'(o_count), 32'd7);
    #2 rst = 1'b1;
    #1;
    check("mid_cap_busy", 32'(o_busy), 32'd0);
    check("mid_cap_count", 32'(o_count), 32'd0);
    i_run = 1'b0;
    step();
    rst = 1'b0;
    step();

    // Reset in the middle of a readout, then a fresh capture.
    do_capture(16'd0, 6, 9, 1'b0, 8'h00);
    push_expected();
    x0 = xfers;
    i_read_start = 1'b1;
    step();
    i_read_start = 1'b0;
    i_rd_ready   = 1'b1;
    for (n = 0; n < 50 && (xfers - x0) < 2; n++) step();
    check("mid_ro_xfers", 32'(xfers - x0), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("mid_ro_valid", 32'(o_rd_valid), 32'd0);
    check("mid_ro_busy", 32'(o_busy), 32'd0);
    sb.delete();
    i_rd_ready = 1'b0;
    step();
    rst = 1'b0;
    step();
    do_capture(16'd0, 9, 12, 1'b0, 8'h00);
    do_readout(2, 1'b0);

    for (int it = 0; it < 6; it++) begin
      do_capture(DIV_WIDTH'($urandom_range(0, 3)), $urandom_range(1, 24), 30, 1'b0, 8'h00);
      do_readout(2, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
